// File: rtl/ipv4_pkg.sv
// Shared constants and types for the IPv4 receive header checker.
package ipv4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [3:0]  IHL_MIN      = 4'd5;
  localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

  localparam logic [7:0] UDP  = 8'h11;
  localparam logic [7:0] ICMP = 8'h01;

endpackage

// File: rtl/oc_add16.sv
// Combinational 16-bit ones'-complement adder with end-around carry.
module oc_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] s;

  assign s = {1'b0, a} + {1'b0, b};
  // A carry folded back into a sum of two 16-bit words cannot carry out again.
  assign y = s[15:0] + {15'd0, s[16]};

endmodule

// File: rtl/ipv4_hdr_checker.sv
// Receive-side IPv4 header checker: recomputes the ones'-complement sum over the
// whole header and reports pass/fail plus the fields the UDP receive path needs.
module ipv4_hdr_checker
  import ipv4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        en,
  input  logic [7:0]  d,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic        err_fmt,
  output logic [5:0]  hdr_len,
  output logic [15:0] total_len,
  output logic [7:0]  protocol
);

  state_t      state_reg;
  logic [15:0] acc_reg;
  logic [5:0]  cnt_reg;
  logic [5:0]  len_reg;
  logic [7:0]  hi_reg;

  logic        start;
  logic        fmt_bad;
  logic [5:0]  len_new;
  logic [15:0] sum;

  assign start   = en & sof;
  assign fmt_bad = (d[7:4] != IPV4_VERSION) || (d[3:0] < IHL_MIN);
  assign len_new = {d[3:0], 2'b00};

  // Folds the word completed by the current byte; only used on odd byte counts.
  oc_add16 u_add (
    .a (acc_reg),
    .b ({hi_reg, d}),
    .y (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= 16'd0;
      cnt_reg   <= 6'd0;
      len_reg   <= 6'd0;
      hi_reg    <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err_fmt   <= 1'b0;
      hdr_len   <= 6'd0;
      total_len <= 16'd0;
      protocol  <= 8'd0;
    end else begin
      done <= 1'b0;
      // A new byte 0 wins in every state: it aborts a header in progress.
      if (start) begin
        if (fmt_bad) begin
          state_reg <= REPORT;
          busy      <= 1'b0;
          done      <= 1'b1;
          ok        <= 1'b0;
          err_fmt   <= 1'b1;
          hdr_len   <= len_new;
        end else begin
          state_reg <= HDR;
          busy      <= 1'b1;
          len_reg   <= len_new;
          hi_reg    <= d;
          acc_reg   <= 16'd0;
          cnt_reg   <= 6'd1;
        end
      end else begin
        case (state_reg)
          HDR: begin
            if (en) begin
              if (cnt_reg[0]) acc_reg <= sum;
              else            hi_reg  <= d;
              if (cnt_reg == 6'd2) total_len[15:8] <= d;
              if (cnt_reg == 6'd3) total_len[7:0]  <= d;
              if (cnt_reg == 6'd9) protocol        <= d;
              cnt_reg <= cnt_reg + 6'd1;
              if (cnt_reg == len_reg - 6'd1) begin
                state_reg <= REPORT;
                busy      <= 1'b0;
                done      <= 1'b1;
                ok        <= (sum == CSUM_GOOD);
                err_fmt   <= 1'b0;
                hdr_len   <= len_reg;
              end
            end
          end
          REPORT:  state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipv4_hdr_checker.sv
// Directed bench for ipv4_hdr_checker with hand-computed expected results.
module tb_ipv4_hdr_checker;
  import ipv4_pkg::*;

  logic        clk;
  logic        rst;
  logic        sof;
  logic        en;
  logic [7:0]  d;
  logic        busy;
  logic        done;
  logic        ok;
  logic        err_fmt;
  logic [5:0]  hdr_len;
  logic [15:0] total_len;
  logic [7:0]  protocol;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] h [0:59];

  ipv4_hdr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .en        (en),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .ok        (ok),
    .err_fmt   (err_fmt),
    .hdr_len   (hdr_len),
    .total_len (total_len),
    .protocol  (protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic put(input logic s, input logic e, input logic [7:0] b);
    @(negedge clk);
    sof = s;
    en  = e;
    d   = b;
  endtask

  task automatic load_good();
    logic [7:0] g [0:19];
    g = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
          8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    for (int i = 0; i < 60; i++) h[i] = 8'h00;
    for (int i = 0; i < 20; i++) h[i] = g[i];
  endtask

  // Streams h[0..len-1]; checks busy after byte 0 and the done pulse timing.
  task automatic send_hdr(input string name, input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      put(i == 0, 1'b1, h[i]);
      if (i == 1) chk({name, "_busy"}, 32'(busy), 32'd1);
      if (i == len - 1) chk({name, "_nodone_early"}, 32'(done), 32'd0);
      if (gaps && i < len - 1) begin
        int n;
        n = $urandom_range(1, 7);
        for (int k = 0; k < n; k++) put(1'b0, 1'b0, 8'hA5);
      end
    end
    put(1'b0, 1'b0, 8'h00);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    $display("hdr %s: done=%0b ok=%0b err_fmt=%0b hdr_len=%0d total_len=%04h protocol=%02h",
             name, done, ok, err_fmt, hdr_len, total_len, protocol);
  endtask

  task automatic expect_res(input string name, input logic eok, input logic eerr,
                            input logic [5:0] elen, input logic [15:0] etl, input logic [7:0] epr);
    chk({name, "_ok"}, 32'(ok), 32'(eok));
    chk({name, "_err_fmt"}, 32'(err_fmt), 32'(eerr));
    chk({name, "_hdr_len"}, 32'(hdr_len), 32'(elen));
    chk({name, "_total_len"}, 32'(total_len), 32'(etl));
    chk({name, "_protocol"}, 32'(protocol), 32'(epr));
    put(1'b0, 1'b0, 8'h00);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_ok"}, 32'(ok), 32'd0);
    chk({name, "_err_fmt"}, 32'(err_fmt), 32'd0);
    chk({name, "_hdr_len"}, 32'(hdr_len), 32'd0);
    chk({name, "_total_len"}, 32'(total_len), 32'd0);
    chk({name, "_protocol"}, 32'(protocol), 32'd0);
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    sof = 1'b0;
    en  = 1'b0;
    d   = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    put(1'b0, 1'b0, 8'h00);

    // en without sof in IDLE is ignored
    put(1'b0, 1'b1, 8'h45);
    put(1'b0, 1'b0, 8'h00);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    load_good();
    send_hdr("good", 20, 1'b0);
    expect_res("good", 1'b1, 1'b0, 6'd20, 16'h0073, UDP);

    load_good();
    h[11] = 8'h62;
    send_hdr("badsum", 20, 1'b0);
    expect_res("badsum", 1'b0, 1'b0, 6'd20, 16'h0073, UDP);

    load_good();
    send_hdr("gaps", 20, 1'b1);
    expect_res("gaps", 1'b1, 1'b0, 6'd20, 16'h0073, UDP);

    load_good();
    h[0]  = 8'h46;
    h[10] = 8'hB7;
    h[11] = 8'h61;
    send_hdr("ihl6", 24, 1'b0);
    expect_res("ihl6", 1'b1, 1'b0, 6'd24, 16'h0073, UDP);

    put(1'b1, 1'b1, 8'h65);
    put(1'b0, 1'b0, 8'h00);
    chk("ver6_done", 32'(done), 32'd1);
    chk("ver6_err_fmt", 32'(err_fmt), 32'd1);
    chk("ver6_ok", 32'(ok), 32'd0);
    chk("ver6_busy", 32'(busy), 32'd0);
    $display("hdr ver6: done=%0b ok=%0b err_fmt=%0b", done, ok, err_fmt);
    put(1'b0, 1'b0, 8'h00);

    // Abort at byte 8, then a complete valid header: exactly one done
    load_good();
    #2 snap = done_cnt;
    for (int i = 0; i < 8; i++) put(i == 0, 1'b1, h[i]);
    send_hdr("abort", 20, 1'b0);
    expect_res("abort", 1'b1, 1'b0, 6'd20, 16'h0073, UDP);
    put(1'b0, 1'b0, 8'h00);
    #2 chk("abort_done_count", 32'(done_cnt - snap), 32'd1);

    // Reset mid-header at byte 10
    load_good();
    snap = done_cnt;
    for (int i = 0; i < 10; i++) put(i == 0, 1'b1, h[i]);
    put(1'b0, 1'b1, h[10]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    put(1'b0, 1'b0, 8'h00);
    put(1'b0, 1'b0, 8'h00);
    #2 chk("midrst_no_done", 32'(done_cnt - snap), 32'd0);
    send_hdr("after_rst", 20, 1'b0);
    expect_res("after_rst", 1'b1, 1'b0, 6'd20, 16'h0073, UDP);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
